data_mem_ctrl: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 9 +
 rtl/dmem_array.sv | 26 ++
 rtl/data_mem_ctrl.sv | 99 +++++++++
 tb/tb_data_mem_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the multi-cycle MIPS data-memory controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
    end

    assign rd = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: stalls the core while a load/store waits
// LATENCY cycles on the array, then commits during a one-cycle DONE state.
module data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] WriteData,
    output logic [WORD_W-1:0] ReadData,
    output logic              stall,
    output logic              misaligned
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              isWrite_q;
    logic [WORD_W-1:0] readData_q;

    logic              anyOp;
    logic              req;
    logic              accessNow;
    logic              arrayWe;
    logic [WORD_W-1:0] arrayRd;
    logic [WORD_W-IDX_W-3:0] unusedAddrBits;

    // Upper address bits are dropped on purpose so addresses wrap modulo DEPTH*4.
    assign unusedAddrBits = addr[WORD_W-1:IDX_W+2];

    assign anyOp      = MemRead | MemWrite;
    assign misaligned = anyOp & (addr[1:0] != 2'b00);
    assign req        = anyOp & ~misaligned;
    assign stall      = ((state_q == IDLE) & req) | (state_q == WAIT);
    assign accessNow  = (state_q == WAIT) & (cnt_q == '0);
    assign arrayWe    = accessNow & isWrite_q;
    assign ReadData   = readData_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk (clk),
        .we  (arrayWe),
        .idx (idx_q),
        .wd  (wdata_q),
        .rd  (arrayRd)
    );

    // Inputs are captured only on IDLE->WAIT; a request still held in DONE
    // belongs to the committing instruction and must not restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            isWrite_q  <= 1'b0;
            readData_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q   <= WAIT;
                        cnt_q     <= CNT_W'(LATENCY - 1);
                        idx_q     <= addr[2 +: IDX_W];
                        wdata_q   <= WriteData;
                        isWrite_q <= MemWrite;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (!isWrite_q) begin
                            readData_q <= arrayRd;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a timeline model.
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int L     = 2;
    localparam int IW    = $clog2(DEPTH);

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        misaligned;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: a transaction timeline keyed on its start cycle.
    logic [31:0]   mdl [DEPTH];
    bit            mvalid [DEPTH];
    bit            busy = 0;
    int            startCyc = 0;
    logic [IW-1:0] tIdx;
    bit            tWrite;
    logic [31:0]   tData;
    logic [31:0]   expRd = '0;
    bit            rdKnown = 1;
    bit            reqNow;
    bit            expStall;
    bit            expMis;
    int            off;

    int          sCnt;
    logic        dStall;
    logic [31:0] dRd;

    data_mem_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (L)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .stall      (stall),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Holds one request for a full access (LATENCY+2 cycles) and reports what it saw.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, output int stallCnt,
                                 output logic doneStall, output logic [31:0] doneRd);
        MemRead   = rd;
        MemWrite  = wr;
        addr      = a;
        WriteData = wd;
        stallCnt  = 0;
        doneStall = 1'b1;
        doneRd    = '0;
        for (int i = 0; i <= L + 1; i++) begin
            @(negedge clk);
            if (stall) stallCnt++;
            if (i == L + 1) begin
                doneStall = stall;
                doneRd    = ReadData;
            end
            @(posedge clk);
            #1;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Model: a request seen while idle starts a transaction; stall spans offsets
    // 0..L, and the access takes effect in offset L+1.
    always @(negedge clk) begin
        if (reset) begin
            busy    = 0;
            expRd   = '0;
            rdKnown = 1;
        end else begin
            reqNow = (MemRead || MemWrite) && (addr[1:0] == 2'b00);
            expMis = (MemRead || MemWrite) && (addr[1:0] != 2'b00);
            if (!busy && reqNow) begin
                busy     = 1;
                startCyc = cyc;
                tIdx     = addr[2 +: IW];
                tWrite   = MemWrite;
                tData    = WriteData;
            end
            off      = cyc - startCyc;
            expStall = busy && (off <= L);
            if (busy && off == L + 1) begin
                if (tWrite) begin
                    mdl[tIdx]    = tData;
                    mvalid[tIdx] = 1;
                end else begin
                    expRd   = mdl[tIdx];
                    rdKnown = mvalid[tIdx];
                end
                busy = 0;
            end
            checkOutput("model stall", {31'b0, stall}, {31'b0, expStall});
            checkOutput("model misaligned", {31'b0, misaligned}, {31'b0, expMis});
            if (rdKnown) checkOutput("model ReadData", ReadData, expRd);
        end
    end

    initial begin
        int r;
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        addr      = '0;
        WriteData = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("reset ReadData", ReadData, 32'h0);
        checkOutput("reset stall", {31'b0, stall}, 32'h0);
        checkOutput("reset misaligned", {31'b0, misaligned}, 32'h0);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, sCnt, dStall, dRd);
        checkOutput("store stall cycles", 32'(sCnt), 32'd3);
        checkOutput("store done stall", {31'b0, dStall}, 32'h0);

        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, sCnt, dStall, dRd);
        checkOutput("load stall cycles", 32'(sCnt), 32'd3);
        checkOutput("load done data", dRd, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("load data hold", ReadData, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 1'b1, 32'h0, 32'h1234, sCnt, dStall, dRd);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, sCnt, dStall, dRd);
        checkOutput("wrap load data", dRd, 32'h1234);

        MemRead = 1'b1;
        addr    = 32'h6;
        repeat (2) begin
            @(negedge clk);
            checkOutput("misaligned flag", {31'b0, misaligned}, 32'h1);
            checkOutput("misaligned stall", {31'b0, stall}, 32'h0);
            checkOutput("misaligned ReadData", ReadData, 32'h1234);
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0;

        applyStimulus(1'b1, 1'b1, 32'hC, 32'h55, sCnt, dStall, dRd);
        checkOutput("rd+wr ReadData unchanged", dRd, 32'h1234);
        applyStimulus(1'b1, 1'b0, 32'hC, 32'h0, sCnt, dStall, dRd);
        checkOutput("rd+wr stored word", dRd, 32'h55);

        applyStimulus(1'b0, 1'b1, 32'h10, 32'h11111111, sCnt, dStall, dRd);
        MemWrite  = 1'b1;
        addr      = 32'h10;
        WriteData = 32'hBADBAD00;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        MemWrite = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("abort stall", {31'b0, stall}, 32'h0);
        checkOutput("abort ReadData", ReadData, 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, sCnt, dStall, dRd);
        checkOutput("abort store dropped", dRd, 32'h11111111);

        // Randomized traffic: inputs change every cycle, including mid-access.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            MemRead   = (r < 4) || (r == 8);
            MemWrite  = (r >= 4 && r < 8) || (r == 8);
            addr      = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            WriteData = $urandom();
            if (n % 700 == 699) reset = 1'b1;
            else reset = 1'b0;
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        repeat (L + 3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
